// File: rtl/downlink_capture.sv
// downlink_capture
//   Captures 40-bit AGC downlink words from four asynchronous strobes and
//   queues them in a 4-entry first-word-fall-through FIFO.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   dkstrt/dkbsnc/dkend   : asynchronous word-start, bit-sync, word-end strobes
//   dkdata                : asynchronous serial data, MSB first
//   clr_flags             : one-cycle pulse clearing overflow and err_count
//   word_data/word_valid  : head of FIFO and its valid flag
//   word_ready            : consumer accept; pop on word_valid && word_ready
//   frame_err             : one-cycle pulse per malformed frame
//   overflow              : sticky, a word was dropped on a full FIFO
//   err_count             : saturating malformed-frame count
//   fifo_level            : FIFO occupancy 0..4
module downlink_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        dkstrt,
    input  logic        dkbsnc,
    input  logic        dkend,
    input  logic        dkdata,
    input  logic        clr_flags,
    output logic [39:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overflow,
    output logic [7:0]  err_count,
    output logic [2:0]  fifo_level
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Synchronizer bit order: [0]=dkstrt [1]=dkbsnc [2]=dkend [3]=dkdata
    logic [3:0]  s1_q, s1_d;
    logic [3:0]  s2_q, s2_d;
    logic [3:0]  dly_q, dly_d;

    state_t      state_q, state_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [39:0] shreg_q, shreg_d;

    logic [39:0] mem_q [4];
    logic [39:0] mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;

    logic        frame_err_q, frame_err_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        strt_rise, bsnc_fall, end_rise, data_bit;
    logic        active;
    logic        err, push;
    logic [39:0] push_word;
    logic        pop, full, wr_en, ovf_set;

    always_comb begin
        s1_d  = {dkdata, dkend, dkbsnc, dkstrt};
        s2_d  = s1_q;
        dly_d = s2_q;
    end

    assign strt_rise = s2_q[0] & ~dly_q[0];
    assign bsnc_fall = ~s2_q[1] & dly_q[1];
    assign end_rise  = s2_q[2] & ~dly_q[2];
    assign data_bit  = s2_q[3];

    // Coincident events are resolved in a fixed order within one cycle:
    // bit shift, then word end, then word start.
    always_comb begin
        active    = (state_q == SHIFT);
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        err       = 1'b0;
        push      = 1'b0;
        push_word = shreg_q;

        if (active && bsnc_fall) begin
            if (bitcnt_q == 6'd40) begin
                err    = 1'b1;
                active = 1'b0;
            end else begin
                shreg_d  = {shreg_q[38:0], data_bit};
                bitcnt_d = bitcnt_q + 6'd1;
            end
        end

        if (active && end_rise) begin
            if (bitcnt_d == 6'd40) begin
                push      = 1'b1;
                push_word = shreg_d;
            end else begin
                err = 1'b1;
            end
            active = 1'b0;
        end

        if (strt_rise) begin
            if (active) begin
                err = 1'b1;
            end
            bitcnt_d = '0;
            shreg_d  = '0;
            active   = 1'b1;
        end

        state_d = active ? SHIFT : IDLE;
    end

    assign word_valid = (count_q != 3'd0);
    assign pop        = word_valid & word_ready;
    assign full       = (count_q == 3'd4);
    assign wr_en      = push & (~full | pop);
    assign ovf_set    = push & full & ~pop;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // A new error or overflow in the same cycle as clr_flags takes priority.
    always_comb begin
        frame_err_d = err;

        err_count_d = err_count_q;
        if (err) begin
            if (clr_flags) begin
                err_count_d = 8'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (clr_flags) begin
            err_count_d = '0;
        end

        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_flags) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            dly_q       <= '0;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            dly_q       <= dly_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

    assign word_data  = word_valid ? mem_q[rd_ptr_q] : '0;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign err_count  = err_count_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_downlink_capture.sv
`timescale 1ns/1ps
module tb_downlink_capture;

    logic        clk = 1'b0;
    logic        rst, dkstrt, dkbsnc, dkend, dkdata, clr_flags, word_ready;
    logic [39:0] word_data;
    logic        word_valid, frame_err, overflow;
    logic [7:0]  err_count;
    logic [2:0]  fifo_level;

    downlink_capture dut (
        .clk        (clk),
        .rst        (rst),
        .dkstrt     (dkstrt),
        .dkbsnc     (dkbsnc),
        .dkend      (dkend),
        .dkdata     (dkdata),
        .clr_flags  (clr_flags),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_count  (err_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: frame-level view of what the bench has sent.
    logic [39:0] mq[$];
    bit          m_in_frame = 1'b0;
    bit          m_bits[$];
    int          m_err      = 0;
    bit          m_ovf      = 1'b0;
    int          m_pulses   = 0;
    int          seen_pulses = 0;

    always @(negedge clk) begin
        if (frame_err === 1'b1) seen_pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_error();
        m_err = (m_err < 255) ? m_err + 1 : 255;
        m_pulses++;
    endfunction

    function automatic void m_start();
        if (m_in_frame) m_error();
        m_in_frame = 1'b1;
        m_bits.delete();
    endfunction

    function automatic void m_bit(input bit b);
        if (!m_in_frame) return;
        if (m_bits.size() == 40) begin
            m_error();
            m_in_frame = 1'b0;
        end else begin
            m_bits.push_back(b);
        end
    endfunction

    function automatic void m_end();
        logic [39:0] w;
        if (!m_in_frame) return;
        m_in_frame = 1'b0;
        if (m_bits.size() == 40) begin
            w = '0;
            foreach (m_bits[i]) w = w * 2 + 40'(m_bits[i]);
            if (mq.size() == 4) m_ovf = 1'b1;
            else mq.push_back(w);
        end else begin
            m_error();
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_start();
        dkstrt = 1'b1; cyc(2); dkstrt = 1'b0; cyc(3);
        m_start();
    endtask

    task automatic drive_bit(input bit b);
        dkdata = b; cyc(1);
        dkbsnc = 1'b1; cyc(3);
        dkbsnc = 1'b0; cyc(3);
        m_bit(b);
    endtask

    task automatic drive_end();
        dkend = 1'b1; cyc(2); dkend = 1'b0; cyc(3);
        m_end();
    endtask

    task automatic send_bits(input logic [39:0] w, input int n);
        logic [39:0] v;
        v = w;
        for (int i = 0; i < n; i++) begin
            if (i < 40) drive_bit(v[39 - i]);
            else drive_bit(1'($urandom));
        end
    endtask

    task automatic send_frame(input logic [39:0] w, input int n, input bit with_end);
        drive_start();
        send_bits(w, n);
        if (with_end) drive_end();
    endtask

    task automatic do_clr();
        clr_flags = 1'b1; cyc(1); clr_flags = 1'b0; cyc(1);
        m_err = 0;
        m_ovf = 1'b0;
    endtask

    task automatic consume_one();
        if (mq.size() == 0) return;
        chk("pop_valid", 64'(word_valid), 64'd1);
        chk("pop_data", 64'(word_data), 64'(mq[0]));
        word_ready = 1'b1; cyc(1); word_ready = 1'b0;
        void'(mq.pop_front());
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".level"}, 64'(fifo_level), 64'(mq.size()));
        chk({tag, ".valid"}, 64'(word_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".head"}, 64'(word_data), 64'(mq[0]));
        chk({tag, ".err_count"}, 64'(err_count), 64'(m_err));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".err_pulses"}, 64'(seen_pulses), 64'(m_pulses));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".word_valid"}, 64'(word_valid), 64'd0);
        chk({tag, ".word_data"}, 64'(word_data), 64'd0);
        chk({tag, ".frame_err"}, 64'(frame_err), 64'd0);
        chk({tag, ".fifo_level"}, 64'(fifo_level), 64'd0);
        chk({tag, ".overflow"}, 64'(overflow), 64'd0);
        chk({tag, ".err_count"}, 64'(err_count), 64'd0);
    endtask

    typedef struct {
        logic [39:0] word;
        int          nbits;
        bit          with_end;
        logic [2:0]  exp_level;
        logic [7:0]  exp_err;
        logic [39:0] exp_head;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [39:0] w;
        int          kind;

        tbl[0] = '{40'hA512345678, 40, 1'b1, 3'd1, 8'd0, 40'hA512345678};
        tbl[1] = '{40'h00DEADBEEF, 39, 1'b1, 3'd1, 8'd1, 40'hA512345678};
        tbl[2] = '{40'h1122334455, 41, 1'b1, 3'd1, 8'd2, 40'hA512345678};
        tbl[3] = '{40'hFFFFFFFFFF, 40, 1'b1, 3'd2, 8'd2, 40'hA512345678};
        tbl[4] = '{40'h0000000000,  0, 1'b1, 3'd2, 8'd3, 40'hA512345678};
        tbl[5] = '{40'h3333333333, 10, 1'b0, 3'd2, 8'd3, 40'hA512345678};
        tbl[6] = '{40'h0123456789, 40, 1'b1, 3'd3, 8'd4, 40'hA512345678};

        rst = 1'b1; dkstrt = 1'b0; dkbsnc = 1'b0; dkend = 1'b0; dkdata = 1'b0;
        clr_flags = 1'b0; word_ready = 1'b0;
        cyc(3);
        check_all_zero("reset");
        rst = 1'b0;
        cyc(2);

        // Table-driven frames, consumer idle
        foreach (tbl[i]) begin
            send_frame(tbl[i].word, tbl[i].nbits, tbl[i].with_end);
            chk("tbl.level", 64'(fifo_level), 64'(tbl[i].exp_level));
            chk("tbl.err_count", 64'(err_count), 64'(tbl[i].exp_err));
            chk("tbl.valid", 64'(word_valid), 64'(tbl[i].exp_level != 0));
            chk("tbl.head", 64'(word_data), 64'(tbl[i].exp_head));
        end
        check_state("tbl_end");
        chk("tbl.drain0", 64'(mq[0]), 64'h00A512345678);
        repeat (3) consume_one();
        check_state("tbl_drained");

        // Overflow on a fifth word, then in-order drain
        do_clr();
        check_state("clr");
        for (int i = 1; i <= 5; i++) send_frame(40'(i), 40, 1'b1);
        chk("ovf.level", 64'(fifo_level), 64'd4);
        chk("ovf.flag", 64'(overflow), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf.order", 64'(word_data), 64'(i));
            consume_one();
        end
        chk("ovf.empty", 64'(word_valid), 64'd0);
        check_state("ovf_end");

        // Push and pop in the same cycle while full
        do_clr();
        for (int i = 0; i < 4; i++) send_frame(40'h10 + 40'(i), 40, 1'b1);
        drive_start();
        send_bits(40'h14, 40);
        dkend = 1'b1; cyc(1);
        chk("full.head", 64'(word_data), 64'h10);
        cyc(1);
        dkend = 1'b0; word_ready = 1'b1;
        cyc(1);
        void'(mq.pop_front());
        m_end();
        chk("full.level", 64'(fifo_level), 64'd4);
        chk("full.overflow", 64'(overflow), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            chk("full.drain", 64'(word_data), 64'h10 + 64'(i));
            cyc(1);
            void'(mq.pop_front());
        end
        word_ready = 1'b0;
        chk("full.empty", 64'(word_valid), 64'd0);
        for (int i = 0; i < 10; i++) begin
            send_frame(40'h5000000000 + 40'(i), 40, 1'b1);
            if (i % 3 == 2) begin
                consume_one();
                consume_one();
            end
        end
        check_state("wrap");
        while (mq.size() != 0) consume_one();

        // Abort by a second start, then a clean frame
        do_clr();
        drive_start();
        send_bits(40'hFFFFF00000, 20);
        send_frame(40'hC0FFEE1234, 40, 1'b1);
        chk("abort.err", 64'(err_count), 64'd1);
        chk("abort.head", 64'(word_data), 64'hC0FFEE1234);
        check_state("abort");
        consume_one();

        // dkend and dkstrt together: push, then a new frame begins
        drive_start();
        send_bits(40'h8000000001, 40);
        dkend = 1'b1; dkstrt = 1'b1; cyc(2);
        dkend = 1'b0; dkstrt = 1'b0; cyc(3);
        m_end(); m_start();
        send_bits(40'h7FFFFFFFFE, 40);
        drive_end();
        chk("coinc.level", 64'(fifo_level), 64'd2);
        check_state("coinc");
        consume_one(); consume_one();

        // clr_flags in the same cycle as a new error
        do_clr();
        drive_start();
        dkstrt = 1'b1; cyc(2);
        dkstrt = 1'b0; clr_flags = 1'b1; cyc(1);
        clr_flags = 1'b0; cyc(2);
        m_err = 0; m_start();
        chk("clr_err.err", 64'(err_count), 64'd1);
        check_state("clr_err");

        // Saturation at 255
        repeat (260) drive_start();
        chk("sat.err", 64'(err_count), 64'd255);
        check_state("sat");

        // Reset mid-word
        send_frame(40'h2222222222, 40, 1'b1);
        drive_start();
        send_bits(40'hABCDEF0123, 17);
        rst = 1'b1; cyc(1);
        check_all_zero("midrst");
        cyc(1); rst = 1'b0;
        mq.delete(); m_in_frame = 1'b0; m_err = 0; m_ovf = 1'b0;
        cyc(2);
        drive_end();
        chk("midrst.level", 64'(fifo_level), 64'd0);
        chk("midrst.err", 64'(err_count), 64'd0);
        send_frame(40'h9876543210, 40, 1'b1);
        chk("midrst.head", 64'(word_data), 64'h9876543210);
        check_state("midrst");

        // Randomized frames against the model
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 9);
            w = {8'($urandom), 32'($urandom)};
            if (kind <= 5) send_frame(w, 40, 1'b1);
            else if (kind == 6) send_frame(w, $urandom_range(1, 39), 1'b1);
            else if (kind == 7) send_frame(w, 41, 1'b1);
            else if (kind == 8) send_frame(w, $urandom_range(0, 5), 1'b0);
            else repeat ($urandom_range(0, 4)) consume_one();
            check_state("rand");
        end
        while (mq.size() != 0) consume_one();
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
